// File: rtl/gpio_pkg.sv
// Shared types and constants for the gpio peripheral and its bus arbiter.
package gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam int NUM_MASTERS = 2;

    // gpio register map
    localparam int unsigned GPIO_CTRL_ADDR = 0;
    localparam int unsigned GPIO_DATA_ADDR = 1;

    // Per-pin mode encoding held in CTRL
    localparam logic [1:0] PIN_MODE_HIZ = 2'b00;
    localparam logic [1:0] PIN_MODE_OUT = 2'b01;
    localparam logic [1:0] PIN_MODE_IN  = 2'b10;

    function automatic arb_state_e gnt_state(input logic sel);
        return sel ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Two-way round-robin pick: selects the master not served last when both
// request; lock masks master 0 so master 1 keeps the bus.
module gpio_rr_pick
    import gpio_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_q,
    input  logic lock,
    output logic sel,
    output logic valid
);

    logic req0_eff;

    assign req0_eff = req0 & ~lock;
    assign valid    = req0_eff | req1;
    assign sel      = (req0_eff & req1) ? ~last_q : req1;

endmodule

// File: rtl/gpio_bus_arb.sv
// Round-robin arbiter sharing the gpio register port between CPU (m0) and
// debug (m1). Define GPIO_ARB_LOCK_EN to build in the m1 bus-lock feature.
module gpio_bus_arb
    import gpio_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    input  logic              m1_lock_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i
);

    arb_state_e              state_reg;
    arb_state_e              state_next;
    logic                    last_q;
    logic                    lock_eff;
    logic                    pick_sel;
    logic                    pick_valid;
    logic                    grant_any;
    logic [NUM_MASTERS-1:0]  req_vec;
    logic [NUM_MASTERS-1:0]  we_vec;
    logic [NUM_MASTERS-1:0]  gnt_vec;
    logic [NUM_MASTERS-1:0]  ack_reg;
    logic [ADDR_W-1:0]       addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]       wdata_arr [NUM_MASTERS];
    logic [DATA_W-1:0]       rdata_reg;

    assign req_vec      = {m1_req_i, m0_req_i};
    assign we_vec       = {m1_we_i, m0_we_i};
    assign addr_arr[0]  = m0_addr_i;
    assign addr_arr[1]  = m1_addr_i;
    assign wdata_arr[0] = m0_wdata_i;
    assign wdata_arr[1] = m1_wdata_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_gnt
            assign gnt_vec[gi] = (state_reg == gnt_state(gi != 0));
        end
    endgenerate

    assign grant_any = |gnt_vec;

`ifdef GPIO_ARB_LOCK_EN
    logic lock_q;

    // Set by a locked m1 access, released by the first idle cycle without lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (state_reg == ST_GNT1 && m1_lock_i) begin
            lock_q <= 1'b1;
        end else if (state_reg == ST_IDLE && !m1_lock_i) begin
            lock_q <= 1'b0;
        end
    end

    assign lock_eff = lock_q;
`else
    logic lock_unused;

    assign lock_unused = m1_lock_i;
    assign lock_eff    = 1'b0;
`endif

    gpio_rr_pick u_pick (
        .req0   (req_vec[0]),
        .req1   (req_vec[1]),
        .last_q (last_q),
        .lock   (lock_eff),
        .sel    (pick_sel),
        .valid  (pick_valid)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = gnt_state(pick_sel);
                end
            end
            ST_GNT0, ST_GNT1: state_next = ST_IDLE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Slave port follows the granted master; idle drives zeros.
    always_comb begin
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_vec[i]) begin
                s_we_o    = we_vec[i];
                s_addr_o  = addr_arr[i];
                s_wdata_o = wdata_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            last_q    <= 1'b1;
            ack_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= gnt_vec;
            if (grant_any) begin
                last_q <= gnt_vec[1];
                if (!s_we_o) begin
                    rdata_reg <= s_rdata_i;
                end
            end
        end
    end

    assign m0_gnt_o = gnt_vec[0];
    assign m1_gnt_o = gnt_vec[1];
    assign m0_ack_o = ack_reg[0];
    assign m1_ack_o = ack_reg[1];
    assign rdata_o  = rdata_reg;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Testbench for gpio_bus_arb: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level arbitration model.
module tb_gpio_bus_arb;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

`ifdef GPIO_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slv_clr = 1'b1;
    logic        mreq [2];
    logic        mwe [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic        m1_lock = 1'b0;

    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, s_we;
    logic [31:0] rdata, s_addr, s_wdata, s_rdata;
    logic [31:0] smem [4];

    gpio_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req_i   (mreq[0]),
        .m0_we_i    (mwe[0]),
        .m0_addr_i  (maddr[0]),
        .m0_wdata_i (mwdata[0]),
        .m0_gnt_o   (m0_gnt),
        .m0_ack_o   (m0_ack),
        .m1_req_i   (mreq[1]),
        .m1_we_i    (mwe[1]),
        .m1_addr_i  (maddr[1]),
        .m1_wdata_i (mwdata[1]),
        .m1_gnt_o   (m1_gnt),
        .m1_ack_o   (m1_ack),
        .m1_lock_i  (m1_lock),
        .rdata_o    (rdata),
        .s_we_o     (s_we),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata)
    );

    always #5 clk = ~clk;

    // Simple register slave standing in for gpio; combinational read.
    assign s_rdata = smem[s_addr[1:0]];
    always @(posedge clk) begin
        if (slv_clr) begin
            for (int i = 0; i < 4; i++) smem[i] <= 32'h0;
        end else if (s_we) begin
            smem[s_addr[1:0]] <= s_wdata;
        end
    end

    int   total = 0;
    int   bad = 0;
    txn_t txq0[$];
    txn_t txq1[$];
    bit   done [2];
    int   lock_mode = 0;
    int   ack_cnt [2];

    // Reference model state
    int          serving;
    int          ack_who;
    bit          last_w;
    bit          lock_w;
    logic [31:0] exp_rdata;
    logic [31:0] ref_mem [4];
    int          gnt_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        if (m == 0) txq0.push_back(t);
        else txq1.push_back(t);
    endtask

    task automatic model_reset(input bit clear_mem);
        serving = -1;
        ack_who = -1;
        last_w = 1'b1;
        lock_w = 1'b0;
        exp_rdata = 32'h0;
        if (clear_mem) for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic drive();
        txn_t t;
        bit   have;
        for (int m = 0; m < 2; m++) begin
            if (done[m]) begin
                mreq[m] = 1'b0;
                done[m] = 1'b0;
            end
            if (!mreq[m]) begin
                have = (m == 0) ? (txq0.size() > 0) : (txq1.size() > 0);
                if (have) begin
                    if (m == 0) t = txq0.pop_front();
                    else t = txq1.pop_front();
                    mreq[m] = 1'b1;
                    mwe[m] = t.we;
                    maddr[m] = t.addr;
                    mwdata[m] = t.wdata;
                end else begin
                    mwe[m] = 1'($urandom_range(1));
                    maddr[m] = $urandom;
                    mwdata[m] = $urandom;
                end
            end
        end
        case (lock_mode)
            0: m1_lock = ($urandom_range(99) < 20);
            1: m1_lock = mreq[1] || (txq1.size() > 0);
            default: m1_lock = 1'b0;
        endcase
    endtask

    task automatic check_cycle();
        logic        e_we;
        logic [31:0] e_addr, e_wd;
        e_we = 1'b0;
        e_addr = 32'h0;
        e_wd = 32'h0;
        if (serving >= 0) begin
            e_we = mwe[serving];
            e_addr = maddr[serving];
            e_wd = mwdata[serving];
        end
        chk("m0_gnt", m0_gnt, serving == 0);
        chk("m1_gnt", m1_gnt, serving == 1);
        chk("m0_ack", m0_ack, ack_who == 0);
        chk("m1_ack", m1_ack, ack_who == 1);
        chk("s_we", s_we, e_we);
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wd);
        chk("rdata", rdata, exp_rdata);
        ack_cnt[0] += int'(m0_ack);
        ack_cnt[1] += int'(m1_ack);
    endtask

    // Advance the model across the next rising edge using the current inputs.
    task automatic model_edge();
        int nxt;
        bit r0, r1;
        nxt = -1;
        ack_who = serving;
        if (serving >= 0) begin
            if (mwe[serving]) ref_mem[maddr[serving][1:0]] = mwdata[serving];
            else exp_rdata = ref_mem[maddr[serving][1:0]];
            last_w = (serving == 1);
            if (LOCK_ON && serving == 1 && m1_lock) lock_w = 1'b1;
            done[serving] = 1'b1;
        end else begin
            r0 = mreq[0] && !lock_w;
            r1 = mreq[1];
            if (r0 && r1) nxt = last_w ? 0 : 1;
            else if (r0) nxt = 0;
            else if (r1) nxt = 1;
            if (!m1_lock) lock_w = 1'b0;
            if (nxt >= 0) gnt_log.push_back(nxt);
        end
        serving = nxt;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        check_cycle();
        model_edge();
    endtask

    function automatic bit is_idle();
        return txq0.size() == 0 && txq1.size() == 0 && !mreq[0] && !mreq[1]
               && serving < 0 && ack_who < 0;
    endfunction

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            step();
            n++;
            idle = is_idle();
        end
        chk({tag, "_done"}, idle, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        slv_clr = 1'b1;
        txq0.delete();
        txq1.delete();
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0;
            done[m] = 1'b0;
        end
        model_reset(1'b1);
        #1;
        check_cycle();
        @(negedge clk);
        slv_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int lock_exp [3];
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0;
            mwe[m] = 1'b0;
            maddr[m] = 32'h0;
            mwdata[m] = 32'h0;
            done[m] = 1'b0;
        end
        model_reset(1'b1);

        // Reset state and single write
        do_reset();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        push(0, 1'b1, 32'h0, 32'h9);
        run_until_idle(20, "single");
        chk("single_ctrl", smem[0], 32'h9);
        chk("single_ack0", ack_cnt[0], 1);
        chk("single_ack1", ack_cnt[1], 0);

        // Read-back by m1
        push(1, 1'b1, 32'h1, 32'h1);
        push(1, 1'b0, 32'h1, 32'h0);
        run_until_idle(20, "readback");
        chk("readback_rdata", rdata, 32'h1);

        // Contention straight after reset
        do_reset();
        gnt_log.delete();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            push(0, 1'($urandom_range(1)), 32'($urandom_range(3)), $urandom);
            push(1, 1'($urandom_range(1)), 32'($urandom_range(3)), $urandom);
        end
        run_until_idle(40, "contend");
        chk("contend_cnt", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size(); i++) chk("contend_order", gnt_log[i], i % 2);
        chk("contend_ack0", ack_cnt[0], 4);
        chk("contend_ack1", ack_cnt[1], 4);

        // Reset asserted in the middle of a GNT0 write
        do_reset();
        push(0, 1'b1, 32'h0, 32'h9);
        step();
        @(negedge clk);
        #1;
        check_cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_we", s_we, 1'b0);
        chk("midrst_gnt0", m0_gnt, 1'b0);
        mreq[0] = 1'b0;
        done[0] = 1'b0;
        model_reset(1'b0);
        @(posedge clk);
        #1;
        chk("midrst_ack0", m0_ack, 1'b0);
        chk("midrst_ctrl", smem[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_log.delete();
        push(0, 1'b0, 32'h0, 32'h0);
        push(1, 1'b0, 32'h1, 32'h0);
        run_until_idle(20, "midrst");
        chk("midrst_cnt", gnt_log.size(), 2);
        chk("midrst_first", gnt_log[0], 0);

        // m1 locked CTRL-then-DATA sequence against continuous m0 traffic
        do_reset();
        gnt_log.delete();
        lock_mode = 1;
        push(1, 1'b1, 32'h0, 32'h5);
        push(1, 1'b1, 32'h1, 32'h3);
        step();
        push(0, 1'b1, 32'h2, 32'h11);
        push(0, 1'b1, 32'h2, 32'h22);
        push(0, 1'b1, 32'h2, 32'h33);
        run_until_idle(60, "lock");
        if (LOCK_ON) lock_exp = '{1, 1, 0};
        else lock_exp = '{1, 0, 1};
        chk("lock_cnt", gnt_log.size(), 5);
        for (int i = 0; i < 3; i++) chk("lock_order", gnt_log[i], lock_exp[i]);
        chk("lock_ctrl", smem[0], 32'h5);
        chk("lock_pins", smem[1][1:0], 2'b11);
        lock_mode = 0;

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (txq0.size() == 0 && $urandom_range(3) == 0)
                push(0, 1'($urandom_range(1)),
                     ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(3)), $urandom);
            if (txq1.size() == 0 && $urandom_range(3) == 0)
                push(1, 1'($urandom_range(1)),
                     ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(3)), $urandom);
            step();
        end
        lock_mode = 2;
        run_until_idle(40, "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
